// File: rtl/guarded_state_reg_bank.sv
// guarded_state_reg_bank
//   Register bank written under a fully decoded 2-bit mode and read with a
//   1-cycle latency. Per-entry init tracking masks reads of never-written
//   entries, flags them on uninit_err and counts them in a saturating
//   counter.
//
// Optional feature macro: GUARDED_BANK_SCRUB_EN
//   Defined:   INIT -> SCRUB (zero every entry, one per cycle) -> RUN.
//   Undefined: INIT -> RUN.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   wr_en       write request (taken only while ready)
//   wr_mode     00 clear, 01 load wr_data, 10 all-ones, 11 hold
//   wr_addr     write entry index
//   wr_data     write data (mode 01 only)
//   rd_en       read request (taken only while ready)
//   rd_addr     read entry index
//   ready       bank accepts requests (RUN state)
//   rd_data     read result, held while rd_valid=0
//   rd_valid    1-cycle pulse one cycle after an accepted read
//   uninit_err  pulses with rd_valid when the entry read was never written
//   err_cnt     saturating count of uninit_err pulses
//   init_map    bit i set once entry i has been written since reset
module guarded_state_reg_bank #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [1:0]                 wr_mode,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic                       ready,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       uninit_err,
  output logic [ERR_CNT_W-1:0]       err_cnt,
  output logic [DEPTH-1:0]           init_map
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_SCRUB = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_in_range;
  logic                rd_in_range;
  logic                wr_sets;
  logic [DATA_W-1:0]   wr_val;
  logic                wr_go;
  logic                rd_go;

`ifdef GUARDED_BANK_SCRUB_EN
  logic [AW-1:0]       scrub_idx;
`endif

  // Range check on a one-bit-wider copy so it stays meaningful when DEPTH
  // is not a power of two.
  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < (AW+1)'(DEPTH));
    rd_in_range = ({1'b0, rd_addr} < (AW+1)'(DEPTH));
  end

  always_comb begin
    wr_sets = 1'b0;
    wr_val  = '0;
    case (wr_mode)
      2'b00: begin
        wr_sets = 1'b1;
        wr_val  = '0;
      end
      2'b01: begin
        wr_sets = 1'b1;
        wr_val  = wr_data;
      end
      2'b10: begin
        wr_sets = 1'b1;
        wr_val  = '1;
      end
      default: begin
        wr_sets = 1'b0;
        wr_val  = '0;
      end
    endcase
  end

  always_comb begin
    ready = (state == ST_RUN);
    wr_go = ready && wr_en && wr_sets && wr_in_range;
    rd_go = ready && rd_en;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: begin
`ifdef GUARDED_BANK_SCRUB_EN
        state_nxt = ST_SCRUB;
`else
        state_nxt = ST_RUN;
`endif
      end
      ST_SCRUB: begin
`ifdef GUARDED_BANK_SCRUB_EN
        if (scrub_idx == AW'(DEPTH - 1)) begin
          state_nxt = ST_RUN;
        end
`else
        state_nxt = ST_RUN;
`endif
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

`ifdef GUARDED_BANK_SCRUB_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scrub_idx <= '0;
    end else if (state == ST_SCRUB) begin
      scrub_idx <= scrub_idx + 1'b1;
    end
  end
`endif

  // Entry storage is deliberately not reset; the reset edge itself must not
  // write, so updates are gated by rst_n.
  always_ff @(posedge clk) begin
    if (rst_n) begin
`ifdef GUARDED_BANK_SCRUB_EN
      if (state == ST_SCRUB) begin
        mem[scrub_idx] <= '0;
      end
`endif
      if (wr_go) begin
        mem[wr_addr] <= wr_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_map <= '0;
    end else begin
`ifdef GUARDED_BANK_SCRUB_EN
      if (state == ST_SCRUB) begin
        init_map[scrub_idx] <= 1'b1;
      end
`endif
      if (wr_go) begin
        init_map[wr_addr] <= 1'b1;
      end
    end
  end

  // Read path samples mem/init_map before this edge's write lands, which
  // gives read-first behaviour on a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid   <= 1'b0;
      uninit_err <= 1'b0;
      rd_data    <= '0;
      err_cnt    <= '0;
    end else begin
      rd_valid   <= rd_go;
      uninit_err <= 1'b0;
      if (rd_go) begin
        if (rd_in_range && init_map[rd_addr]) begin
          rd_data <= mem[rd_addr];
        end else begin
          rd_data    <= '0;
          uninit_err <= 1'b1;
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_guarded_state_reg_bank.sv
// tb_guarded_state_reg_bank
//   Self-checking bench for guarded_state_reg_bank (DATA_W=8, DEPTH=4,
//   ERR_CNT_W=8). Read results are checked through an expected-value queue;
//   a vector table covers the single-cycle behaviour and short hand-written
//   sequences cover reset, saturation and (with GUARDED_BANK_SCRUB_EN) the
//   scrub start-up.
module tb_guarded_state_reg_bank;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_mode;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [1:0] rd_addr;
  logic       ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       uninit_err;
  logic [7:0] err_cnt;
  logic [3:0] init_map;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic       we;
    logic [1:0] mode;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic       re;
    logic [1:0] raddr;
    logic [7:0] exp_d;
    logic       exp_e;
    logic [3:0] exp_map;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[10];

  guarded_state_reg_bank #(
    .DATA_W    (8),
    .DEPTH     (4),
    .ERR_CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_mode    (wr_mode),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .ready      (ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .uninit_err (uninit_err),
    .err_cnt    (err_cnt),
    .init_map   (init_map)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] mode, input logic [1:0] waddr,
                       input logic [7:0] wdata, input logic re, input logic [1:0] raddr);
    wr_en   = we;
    wr_mode = mode;
    wr_addr = waddr;
    wr_data = wdata;
    rd_en   = re;
    rd_addr = raddr;
  endtask

  task automatic idle();
    drive(1'b0, 2'b11, 2'd0, 8'h00, 1'b0, 2'd0);
  endtask

  // Scoreboard: every rd_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_rd_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e.d));
        chk("uninit_err", 32'(uninit_err), 32'(e.e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int cyc;
    rst_n = 1'b0;
    idle();

    //          we    mode   wa    wdata  re    ra    exp_d  e     map      cnt
    vecs[0] = '{1'b0, 2'b11, 2'd0, 8'h00, 1'b1, 2'd2, 8'h00, 1'b1, 4'b0000, 8'd1};
    vecs[1] = '{1'b1, 2'b01, 2'd1, 8'hA5, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0010, 8'd1};
    vecs[2] = '{1'b1, 2'b10, 2'd2, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0110, 8'd1};
    vecs[3] = '{1'b1, 2'b00, 2'd3, 8'h77, 1'b0, 2'd0, 8'h00, 1'b0, 4'b1110, 8'd1};
    vecs[4] = '{1'b1, 2'b11, 2'd1, 8'h3C, 1'b0, 2'd0, 8'h00, 1'b0, 4'b1110, 8'd1};
    vecs[5] = '{1'b0, 2'b11, 2'd0, 8'h00, 1'b1, 2'd1, 8'hA5, 1'b0, 4'b1110, 8'd1};
    vecs[6] = '{1'b0, 2'b11, 2'd0, 8'h00, 1'b1, 2'd2, 8'hFF, 1'b0, 4'b1110, 8'd1};
    vecs[7] = '{1'b0, 2'b11, 2'd0, 8'h00, 1'b1, 2'd3, 8'h00, 1'b0, 4'b1110, 8'd1};
    vecs[8] = '{1'b1, 2'b01, 2'd0, 8'h5A, 1'b1, 2'd0, 8'h00, 1'b1, 4'b1111, 8'd2};
    vecs[9] = '{1'b0, 2'b11, 2'd0, 8'h00, 1'b1, 2'd0, 8'h5A, 1'b0, 4'b1111, 8'd2};

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_uninit_err", 32'(uninit_err), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_init_map", 32'(init_map), 32'd0);

`ifdef GUARDED_BANK_SCRUB_EN
    // Start-up with scrub: read of addr3 held from release onwards.
    rst_n = 1'b1;
    drive(1'b0, 2'b11, 2'd0, 8'h00, 1'b1, 2'd3);
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ready) begin
        cyc = c;
        break;
      end
    end
    chk("scrub_ready_cycle", 32'(cyc), 32'd5);
    chk("scrub_init_map", 32'(init_map), 32'hF);
    sb.push_back('{d: 8'h00, e: 1'b0});
    @(negedge clk);
    idle();
    chk("scrub_rd_valid", 32'(rd_valid), 32'd1);
`else
    // Release with requests present during INIT: they must be dropped.
    rst_n = 1'b1;
    drive(1'b1, 2'b01, 2'd2, 8'h11, 1'b1, 2'd2);
    #1;
    chk("init_ready", 32'(ready), 32'd0);
    @(negedge clk);
    chk("run_ready", 32'(ready), 32'd1);
    chk("init_drop_map", 32'(init_map), 32'd0);
    chk("init_drop_rd_valid", 32'(rd_valid), 32'd0);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].we, vecs[i].mode, vecs[i].waddr, vecs[i].wdata, vecs[i].re, vecs[i].raddr);
      if (vecs[i].re) sb.push_back('{d: vecs[i].exp_d, e: vecs[i].exp_e});
      @(negedge clk);
      chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].re));
      chk($sformatf("vec%0d_init_map", i), 32'(init_map), 32'(vecs[i].exp_map));
      chk($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), 32'(vecs[i].exp_cnt));
    end

    // No read: rd_valid low, rd_data holds the last result.
    idle();
    @(negedge clk);
    chk("hold_rd_valid", 32'(rd_valid), 32'd0);
    chk("hold_rd_data", 32'(rd_data), 32'h5A);
    chk("hold_uninit_err", 32'(uninit_err), 32'd0);

    // Read, then a read coinciding with reset: the second result is discarded.
    drive(1'b0, 2'b11, 2'd0, 8'h00, 1'b1, 2'd0);
    sb.push_back('{d: 8'h5A, e: 1'b0});
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 2'b10, 2'd3, 8'h00, 1'b1, 2'd0);
    @(negedge clk);
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    chk("midrst_init_map", 32'(init_map), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    idle();
    #1;
    chk("midrst_init_ready", 32'(ready), 32'd0);
    @(negedge clk);
    chk("midrst_run_ready", 32'(ready), 32'd1);

    // 260 reads of an uninitialised entry: counter saturates at 0xFF.
    for (int i = 0; i < 260; i++) begin
      drive(1'b0, 2'b11, 2'd0, 8'h00, 1'b1, 2'd1);
      sb.push_back('{d: 8'h00, e: 1'b1});
      @(negedge clk);
      if (i == 253) chk("sat_err_cnt_fe", 32'(err_cnt), 32'hFE);
    end
    idle();
    chk("sat_err_cnt_ff", 32'(err_cnt), 32'hFF);

    // Entry 0 kept its contents across reset but is masked as uninitialised.
    drive(1'b0, 2'b11, 2'd0, 8'h00, 1'b1, 2'd0);
    sb.push_back('{d: 8'h00, e: 1'b1});
    @(negedge clk);
    idle();
    chk("post_sat_err_cnt", 32'(err_cnt), 32'hFF);
`endif

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
